pe_stream: RTL and testbench

Parametrised, row-stationary processing element for the neural-processor PE array. It is the successor to the fixed-length `pe`, and adds:
- a runtime filter length, stride and output count;
- valid/ready handshakes on every stream;
- a sliding ifmap window;
- a wide psum path.

Filter weights stay resident across a full row of outputs. Each output is a dot product of the filter with the current ifmap window, optionally added to an upstream psum, and is then streamed to the next PE.

---
 rtl/pe_stream_pkg.sv | 33 +++
 rtl/pe_circ_rf.sv | 43 ++++
 rtl/pe_stream.sv | 208 ++++++++++++++++++++
 tb/tb_pe_stream.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_stream_pkg.sv
// Shared types and helpers for the streaming row-stationary PE.
// Holds the FSM state type, the product width rule and the config clamp functions.
package pe_stream_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMac,
    StAcc,
    StOut
  } state_e;

  // A full-precision product of two BITWIDTH operands needs twice the width.
  localparam int unsigned ProdMult = 2;

  function automatic int unsigned prod_width(input int unsigned bitwidth);
    return ProdMult * bitwidth;
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    if (len == 0) return 1;
    if (len > depth) return depth;
    return len;
  endfunction

  function automatic int unsigned clamp_stride(input int unsigned stride,
                                               input int unsigned len);
    if (stride == 0) return 1;
    if (stride > len) return len;
    return stride;
  endfunction

endpackage

// File: rtl/pe_circ_rf.sv
// Circular register file: writes land at the tail, reads come from head + offset,
// and the head can be advanced by a stride to slide the window.
module pe_circ_rf #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clear,
  input  logic                  i_wr_en,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [ADDR_WIDTH-1:0] i_rd_offset,
  output logic [WIDTH-1:0]      o_rd_data,
  input  logic                  i_advance,
  input  logic [ADDR_WIDTH-1:0] i_adv_by
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      r_mem [Depth];
  logic [ADDR_WIDTH-1:0] r_head;
  logic [ADDR_WIDTH-1:0] r_tail;
  logic [ADDR_WIDTH-1:0] w_rd_addr;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_wr_en) r_tail <= r_tail + 1'b1;
      // Pointer arithmetic wraps naturally at the power-of-two depth.
      if (i_advance) r_head <= r_head + i_adv_by;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_tail] <= i_wr_data;
  end

  assign w_rd_addr = r_head + i_rd_offset;
  assign o_rd_data = r_mem[w_rd_addr];

endmodule

// File: rtl/pe_stream.sv
// Row-stationary processing element: resident filter, sliding ifmap window,
// one MAC per cycle, optional upstream psum add, handshaked psum output.
module pe_stream
  import pe_stream_pkg::*;
#(
  parameter int unsigned BITWIDTH      = 16,
  parameter int unsigned PSUM_WIDTH    = 32,
  parameter int unsigned RF_ADDR_WIDTH = 3,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_valid,
  input  logic [RF_ADDR_WIDTH:0]   cfg_filter_len,
  input  logic [RF_ADDR_WIDTH:0]   cfg_stride,
  input  logic [CNT_WIDTH-1:0]     cfg_num_out,
  input  logic                     cfg_acc_in,
  input  logic [BITWIDTH-1:0]      filter_in,
  input  logic                     filter_valid,
  output logic                     filter_ready,
  input  logic [BITWIDTH-1:0]      ifmap_in,
  input  logic                     ifmap_valid,
  output logic                     ifmap_ready,
  input  logic [PSUM_WIDTH-1:0]    psum_in,
  input  logic                     psum_in_valid,
  output logic                     psum_in_ready,
  output logic [PSUM_WIDTH-1:0]    psum_out,
  output logic                     psum_out_valid,
  input  logic                     psum_out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned Depth     = 2 ** RF_ADDR_WIDTH;
  localparam int unsigned LenWidth  = RF_ADDR_WIDTH + 1;
  localparam int unsigned ProdWidth = prod_width(BITWIDTH);

  state_e r_state;
  state_e w_state_next;

  logic [LenWidth-1:0]   r_len;
  logic [LenWidth-1:0]   r_stride;
  logic [LenWidth-1:0]   r_fcnt;
  logic [LenWidth-1:0]   r_icnt;
  logic [LenWidth-1:0]   r_k;
  logic [CNT_WIDTH-1:0]  r_num_out;
  logic [CNT_WIDTH-1:0]  r_ocnt;
  logic                  r_acc_in;
  logic                  r_done;
  logic [PSUM_WIDTH-1:0] r_acc;
  logic [PSUM_WIDTH-1:0] r_out;

  logic [LenWidth-1:0]         w_len_clamp;
  logic [LenWidth-1:0]         w_stride_clamp;
  logic [CNT_WIDTH-1:0]        w_ocnt_inc;
  logic                        w_cfg_accept;
  logic                        w_acc_fire;
  logic                        w_out_hs;
  logic                        w_next_window;
  logic                        w_f_hs;
  logic                        w_i_hs;
  logic signed [BITWIDTH-1:0]  w_f_rd;
  logic signed [BITWIDTH-1:0]  w_i_rd;
  logic signed [ProdWidth-1:0] w_prod;
  logic [PSUM_WIDTH-1:0]       w_prod_ext;

  assign w_len_clamp    = LenWidth'(clamp_len(32'(cfg_filter_len), Depth));
  assign w_stride_clamp = LenWidth'(clamp_stride(32'(cfg_stride), 32'(w_len_clamp)));
  assign w_ocnt_inc     = r_ocnt + 1'b1;

  assign w_f_hs = filter_valid && filter_ready;
  assign w_i_hs = ifmap_valid && ifmap_ready;

  // Operands are sign-extended to the product width before multiplying.
  assign w_prod     = ProdWidth'(w_f_rd) * ProdWidth'(w_i_rd);
  assign w_prod_ext = PSUM_WIDTH'(w_prod);

  assign w_next_window = w_out_hs && (w_state_next == StLoad);

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // Readies depend only on registered state and counts, never on a valid input.
  always_comb begin
    w_state_next   = r_state;
    filter_ready   = 1'b0;
    ifmap_ready    = 1'b0;
    psum_in_ready  = 1'b0;
    psum_out_valid = 1'b0;
    w_cfg_accept   = 1'b0;
    w_acc_fire     = 1'b0;
    w_out_hs       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (cfg_valid) begin
          w_cfg_accept = 1'b1;
          if (cfg_num_out != '0) w_state_next = StLoad;
        end
      end
      StLoad: begin
        filter_ready = (r_fcnt < r_len);
        ifmap_ready  = (r_icnt < r_len);
        if ((r_fcnt == r_len) && (r_icnt == r_len)) w_state_next = StMac;
      end
      StMac: begin
        if (r_k == r_len - 1'b1) w_state_next = StAcc;
      end
      StAcc: begin
        psum_in_ready = r_acc_in;
        if (!r_acc_in || psum_in_valid) begin
          w_acc_fire   = 1'b1;
          w_state_next = StOut;
        end
      end
      StOut: begin
        psum_out_valid = 1'b1;
        if (psum_out_ready) begin
          w_out_hs     = 1'b1;
          w_state_next = (w_ocnt_inc == r_num_out) ? StIdle : StLoad;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_stride  <= '0;
      r_fcnt    <= '0;
      r_icnt    <= '0;
      r_k       <= '0;
      r_num_out <= '0;
      r_ocnt    <= '0;
      r_acc_in  <= 1'b0;
      r_done    <= 1'b0;
      r_acc     <= '0;
      r_out     <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_cfg_accept) begin
        r_len     <= w_len_clamp;
        r_stride  <= w_stride_clamp;
        r_num_out <= cfg_num_out;
        r_acc_in  <= cfg_acc_in;
        r_fcnt    <= '0;
        r_icnt    <= '0;
        r_ocnt    <= '0;
        r_k       <= '0;
        r_acc     <= '0;
        r_done    <= (cfg_num_out == '0);
      end
      if (w_f_hs) r_fcnt <= r_fcnt + 1'b1;
      if (w_i_hs) r_icnt <= r_icnt + 1'b1;
      if (r_state == StMac) begin
        r_acc <= r_acc + w_prod_ext;
        r_k   <= (w_state_next == StAcc) ? '0 : r_k + 1'b1;
      end
      if (w_acc_fire) begin
        r_out <= r_acc + (r_acc_in ? psum_in : '0);
        r_acc <= '0;
      end
      if (w_out_hs) begin
        r_ocnt <= w_ocnt_inc;
        if (w_state_next == StIdle) r_done <= 1'b1;
        else                        r_icnt <= r_icnt - r_stride;
      end
    end
  end

  assign psum_out = r_out;
  assign busy     = (r_state != StIdle);
  assign done     = r_done;

  // Filter window never slides; its head stays at zero for the whole row.
  pe_circ_rf #(
    .WIDTH     (BITWIDTH),
    .ADDR_WIDTH(RF_ADDR_WIDTH)
  ) u_filter_rf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_cfg_accept),
    .i_wr_en    (w_f_hs),
    .i_wr_data  (filter_in),
    .i_rd_offset(r_k[RF_ADDR_WIDTH-1:0]),
    .o_rd_data  (w_f_rd),
    .i_advance  (1'b0),
    .i_adv_by   ('0)
  );

  pe_circ_rf #(
    .WIDTH     (BITWIDTH),
    .ADDR_WIDTH(RF_ADDR_WIDTH)
  ) u_ifmap_rf (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_clear    (w_cfg_accept),
    .i_wr_en    (w_i_hs),
    .i_wr_data  (ifmap_in),
    .i_rd_offset(r_k[RF_ADDR_WIDTH-1:0]),
    .o_rd_data  (w_i_rd),
    .i_advance  (w_next_window),
    .i_adv_by   (r_stride[RF_ADDR_WIDTH-1:0])
  );

endmodule

// File: tb/tb_pe_stream.sv
// Directed bench for pe_stream: stream drivers feed filter/ifmap queues, and a
// monitor pops expected psums from a scoreboard on every output handshake.
module tb_pe_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic [3:0]  cfg_filter_len;
  logic [3:0]  cfg_stride;
  logic [15:0] cfg_num_out;
  logic        cfg_acc_in;
  logic [15:0] filter_in;
  logic        filter_valid;
  logic        filter_ready;
  logic [15:0] ifmap_in;
  logic        ifmap_valid;
  logic        ifmap_ready;
  logic [31:0] psum_in;
  logic        psum_in_valid;
  logic        psum_in_ready;
  logic [31:0] psum_out;
  logic        psum_out_valid;
  logic        psum_out_ready;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pe_stream dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_valid     (cfg_valid),
    .cfg_filter_len(cfg_filter_len),
    .cfg_stride    (cfg_stride),
    .cfg_num_out   (cfg_num_out),
    .cfg_acc_in    (cfg_acc_in),
    .filter_in     (filter_in),
    .filter_valid  (filter_valid),
    .filter_ready  (filter_ready),
    .ifmap_in      (ifmap_in),
    .ifmap_valid   (ifmap_valid),
    .ifmap_ready   (ifmap_ready),
    .psum_in       (psum_in),
    .psum_in_valid (psum_in_valid),
    .psum_in_ready (psum_in_ready),
    .psum_out      (psum_out),
    .psum_out_valid(psum_out_valid),
    .psum_out_ready(psum_out_ready),
    .busy          (busy),
    .done          (done)
  );

  logic [15:0] f_q[$];
  logic [15:0] i_q[$];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          f_loads = 0;
  int          i_loads = 0;
  time         last_f_t = 0;
  time         last_i_t = 0;
  time         rise_t = 0;
  time         last_out_hs_t = 0;
  time         done_t = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Filter stream driver
  initial begin
    logic        hs;
    logic [15:0] dummy;
    filter_valid = 1'b0;
    filter_in    = '0;
    forever begin
      @(negedge clk);
      hs = filter_valid && filter_ready;
      @(posedge clk);
      if (hs) begin
        dummy = f_q.pop_front();
        f_loads++;
        last_f_t = $time;
      end
      #1;
      filter_valid = (f_q.size() != 0);
      filter_in    = (f_q.size() != 0) ? f_q[0] : '0;
    end
  end

  // Ifmap stream driver
  initial begin
    logic        hs;
    logic [15:0] dummy;
    ifmap_valid = 1'b0;
    ifmap_in    = '0;
    forever begin
      @(negedge clk);
      hs = ifmap_valid && ifmap_ready;
      @(posedge clk);
      if (hs) begin
        dummy = i_q.pop_front();
        i_loads++;
        last_i_t = $time;
      end
      #1;
      ifmap_valid = (i_q.size() != 0);
      ifmap_in    = (i_q.size() != 0) ? i_q[0] : '0;
    end
  end

  // Output monitor / scoreboard
  initial begin
    logic        prev_valid;
    logic [31:0] exp;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (psum_out_valid && !prev_valid) rise_t = $time;
      prev_valid = psum_out_valid;
      if (psum_out_valid && psum_out_ready) begin
        last_out_hs_t = $time;
        n_out++;
        check("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          exp = sb_q.pop_front();
          check("psum_out", 64'(psum_out), 64'(exp));
        end
      end
    end
  end

  task automatic apply_cfg(input int l, input int s, input int n, input bit acc);
    @(posedge clk); #1;
    cfg_filter_len = 4'(l);
    cfg_stride     = 4'(s);
    cfg_num_out    = 16'(n);
    cfg_acc_in     = acc;
    cfg_valid      = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic push_f(input int v);
    f_q.push_back(16'(v));
  endtask

  task automatic push_i(input int v);
    i_q.push_back(16'(v));
  endtask

  task automatic expect_out(input int v);
    sb_q.push_back(32'(v));
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    done_t = $time;
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic load_basic();
    for (int v = 1; v <= 3; v++) begin
      push_f(v);
      push_i(v);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(psum_out_valid), 64'd0);
    check({tag, "_f_ready"}, 64'(filter_ready), 64'd0);
    check({tag, "_i_ready"}, 64'(ifmap_ready), 64'd0);
    check({tag, "_p_ready"}, 64'(psum_in_ready), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_psum_out"}, 64'(psum_out), 64'd0);
  endtask

  initial begin
    time t_load;
    int  n_before;
    bit  seen;
    rst            = 1'b1;
    cfg_valid      = 1'b0;
    cfg_filter_len = '0;
    cfg_stride     = '0;
    cfg_num_out    = '0;
    cfg_acc_in     = 1'b0;
    psum_in        = '0;
    psum_in_valid  = 1'b0;
    psum_out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic dot product with first-output latency and done timing
    apply_cfg(3, 1, 1, 0);
    expect_out(14);
    load_basic();
    wait_done("basic_done");
    t_load = (last_f_t > last_i_t) ? last_f_t : last_i_t;
    check("basic_latency", 64'(rise_t - t_load), 64'd55);
    check("basic_done_delay", 64'(done_t - last_out_hs_t), 64'd10);
    check("basic_busy_at_done", 64'(busy), 64'd0);

    // Sliding window: filters loaded once for all three outputs
    f_loads = 0;
    i_loads = 0;
    apply_cfg(3, 1, 3, 0);
    expect_out(14);
    expect_out(20);
    expect_out(26);
    for (int v = 1; v <= 3; v++) push_f(v);
    for (int v = 1; v <= 5; v++) push_i(v);
    wait_done("slide_done");
    check("slide_filter_loads", 64'(f_loads), 64'd3);
    check("slide_ifmap_loads", 64'(i_loads), 64'd5);

    // Accumulate upstream psum after a 4-cycle delay
    apply_cfg(3, 1, 1, 1);
    expect_out(114);
    load_basic();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (psum_in_ready) seen = 1'b1;
    end
    check("acc_ready_seen", 64'(psum_in_ready), 64'd1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("acc_ready_wait", 64'(psum_in_ready), 64'd1);
      check("acc_no_out_wait", 64'(psum_out_valid), 64'd0);
    end
    @(posedge clk); #1;
    psum_in       = 32'd100;
    psum_in_valid = 1'b1;
    @(posedge clk); #1;
    psum_in_valid = 1'b0;
    wait_done("acc_done");

    // Signed extremes, negative result, L=0 clamp
    apply_cfg(1, 1, 1, 0);
    expect_out(32'h4000_0000);
    push_f(-32768);
    push_i(-32768);
    wait_done("min_sq_done");

    apply_cfg(1, 1, 1, 0);
    expect_out(-6);
    push_f(-2);
    push_i(3);
    wait_done("neg_done");

    f_loads = 0;
    apply_cfg(0, 0, 1, 0);
    expect_out(-35);
    push_f(5);
    push_i(-7);
    wait_done("len0_done");
    check("len0_filter_loads", 64'(f_loads), 64'd1);

    // N=0: done pulse, no outputs, no readies
    n_before = n_out;
    apply_cfg(3, 1, 0, 0);
    @(negedge clk);
    check("n0_done", 64'(done), 64'd1);
    check("n0_busy", 64'(busy), 64'd0);
    check("n0_f_ready", 64'(filter_ready), 64'd0);
    @(negedge clk);
    check("n0_done_pulse", 64'(done), 64'd0);
    check("n0_no_outputs", 64'(n_out), 64'(n_before));

    // Stride clamped to L, and L clamped to depth
    i_loads = 0;
    apply_cfg(2, 5, 2, 0);
    expect_out(3);
    expect_out(7);
    push_f(1);
    push_f(1);
    for (int v = 1; v <= 4; v++) push_i(v);
    wait_done("sclamp_done");
    check("sclamp_ifmap_loads", 64'(i_loads), 64'd4);

    f_loads = 0;
    apply_cfg(12, 1, 1, 0);
    expect_out(36);
    for (int v = 1; v <= 8; v++) begin
      push_f(1);
      push_i(v);
    end
    wait_done("lclamp_done");
    check("lclamp_filter_loads", 64'(f_loads), 64'd8);

    // Back-pressure on psum_out
    psum_out_ready = 1'b0;
    apply_cfg(3, 1, 1, 0);
    expect_out(14);
    load_basic();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (psum_out_valid) seen = 1'b1;
    end
    check("bp_valid_seen", 64'(psum_out_valid), 64'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_stable", 64'(psum_out), 64'd14);
      check("bp_valid", 64'(psum_out_valid), 64'd1);
      check("bp_f_ready", 64'(filter_ready), 64'd0);
      check("bp_i_ready", 64'(ifmap_ready), 64'd0);
      check("bp_p_ready", 64'(psum_in_ready), 64'd0);
    end
    @(posedge clk); #1;
    psum_out_ready = 1'b1;
    wait_done("bp_done");

    // Reset during MAC, then a fresh basic row
    apply_cfg(3, 1, 1, 0);
    load_basic();
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (f_q.size() == 0 && i_q.size() == 0) seen = 1'b1;
    end
    @(posedge clk); #1;
    check("mac_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_rst");

    apply_cfg(3, 1, 1, 0);
    expect_out(14);
    load_basic();
    wait_done("post_rst_done");
    t_load = (last_f_t > last_i_t) ? last_f_t : last_i_t;
    check("post_rst_latency", 64'(rise_t - t_load), 64'd55);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    check("total_outputs", 64'(n_out), 64'd13);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
